// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one request/ready access per load or store,
// lane-aligns store data and byte enables, extends load data, and stalls upstream while busy.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  dbg_state
);

    // Handshake: dmem_req is high for every BUSY cycle and the request fields stay
    // constant; a cycle with dmem_req=1 and dmem_ready=1 completes the access.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [8:0]  wait_inc;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic        ld_op;

    logic        op;
    logic        is_conflict;
    logic        is_illegal;
    logic        is_misaligned;
    logic        op_err;
    logic        accept;
    logic        ready_hit;
    logic        timeout_hit;
    logic [31:0] wdata_lane;
    logic [3:0]  be_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign op          = mem_read | mem_write;
    assign is_conflict = mem_read & mem_write;

    always_comb begin
        is_illegal = 1'b0;
        if (mem_write) begin
            is_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end else if (mem_read) begin
            is_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
    end

    assign is_misaligned = ((funct3[1:0] == 2'b01) && alu_result[0])
                        || ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    assign op_err      = op & (is_conflict | is_illegal | is_misaligned);
    assign accept      = (state == IDLE) & op & ~op_err;
    assign ready_hit   = (state == BUSY) & dmem_ready;
    assign wait_inc    = {1'b0, wait_cnt} + 9'd1;
    assign timeout_hit = (state == BUSY) & ~dmem_ready & (wait_inc == TIMEOUT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: begin
                if (dmem_ready) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dmem_req  = (state == BUSY);
    // Gated by rst so the pipeline is released the instant reset asserts.
    assign stall     = ~rst & (accept | (state == BUSY));
    assign dbg_state = state;

    always_comb begin
        wdata_lane = store_data;
        be_lane    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_lane = {4{store_data[7:0]}};
                be_lane    = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                wdata_lane = {2{store_data[15:0]}};
                be_lane    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_lane = store_data;
                be_lane    = 4'b1111;
            end
        endcase
    end

    assign ld_byte = dmem_rdata[8*ld_off +: 8];
    assign ld_half = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_ext = dmem_rdata;
        case (ld_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            wait_cnt   <= 8'd0;
            ld_funct3  <= 3'd0;
            ld_off     <= 2'd0;
            ld_op      <= 1'b0;
        end else begin
            fault      <= ((state == IDLE) & op_err) | timeout_hit;
            load_valid <= ready_hit & ld_op;
            if (accept) begin
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_we    <= mem_write;
                dmem_be    <= be_lane;
                dmem_wdata <= wdata_lane;
                ld_funct3  <= funct3;
                ld_off     <= alu_result[1:0];
                ld_op      <= mem_read;
                wait_cnt   <= 8'd0;
            end else if ((state == BUSY) && !dmem_ready) begin
                wait_cnt <= wait_inc[7:0];
            end
            // load_data survives stores and faults until the next completed load.
            if (ready_hit && ld_op) begin
                load_data <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage: loads, stores, faults, timeout, async reset.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        fault;
    logic [1:0]  dbg_state;

    int tests;
    int fails;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_result (alu_result),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .load_data  (load_data),
        .load_valid (load_valid),
        .stall      (stall),
        .fault      (fault),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at posedge+1 in IDLE, returns at posedge+1 of the IDLE cycle after DONE.
    task automatic transact(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int waits,
                            output int stall_cyc, output logic req_seen,
                            output logic [31:0] q_addr, output logic [31:0] q_wdata,
                            output logic [3:0] q_be, output logic q_we,
                            output logic lv, output logic [31:0] ld);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = addr;
        store_data = sd;
        dmem_ready = 1'b0;
        stall_cyc  = 0;
        req_seen   = 1'b0;
        q_addr     = 32'd0;
        q_wdata    = 32'd0;
        q_be       = 4'd0;
        q_we       = 1'b0;
        @(negedge clk);
        if (stall) stall_cyc++;
        @(posedge clk); #1;
        for (int i = 0; i <= waits; i++) begin
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'hA5A5_A5A5;
            @(negedge clk);
            if (stall) stall_cyc++;
            if (i == 0) begin
                req_seen = dmem_req;
                q_addr   = dmem_addr;
                q_wdata  = dmem_wdata;
                q_be     = dmem_be;
                q_we     = dmem_we;
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        @(negedge clk);
        if (stall) stall_cyc++;
        lv = load_valid;
        ld = load_data;
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        alu_result = 32'h0;
        store_data = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #3;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        tests++; if ({dmem_addr, dmem_wdata} !== 64'd0) begin fails++; $display("FAIL reset_addr_wdata: got %h %h expected 0 0", dmem_addr, dmem_wdata); end
        tests++; if ({dmem_we, dmem_be, load_valid, fault} !== 7'd0) begin fails++; $display("FAIL reset_ctrl: got %b expected 0", {dmem_we, dmem_be, load_valid, fault}); end
        tests++; if (load_data !== 32'd0) begin fails++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        transact(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (sc !== 2) begin fails++; $display("FAIL lb_stall_cycles: got %0d expected 2", sc); end
        tests++; if (rq !== 1'b1) begin fails++; $display("FAIL lb_req: got %b expected 1", rq); end
        tests++; if (a !== 32'h1000) begin fails++; $display("FAIL lb_addr: got %h expected 00001000", a); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL lb_we: got %b expected 0", we); end
        tests++; if (lv !== 1'b1) begin fails++; $display("FAIL lb_load_valid: got %b expected 1", lv); end
        tests++; if (ld !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data: got %h expected ffffff80", ld); end
        @(negedge clk);
        tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL lb_valid_pulse: got %b expected 0", load_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_lhu_lh();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        transact(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (ld !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_data: got %h expected 0000beef", ld); end
        tests++; if (a !== 32'h2000) begin fails++; $display("FAIL lhu_addr: got %h expected 00002000", a); end
        transact(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'hBEEF_0000, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (ld !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_data: got %h expected ffffbeef", ld); end
        tests++; if (lv !== 1'b1) begin fails++; $display("FAIL lh_load_valid: got %b expected 1", lv); end
    endtask

    task automatic test_store();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        transact(1'b0, 1'b1, 3'b000, 32'h3001, 32'h0000_00AB, 32'h0, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (a !== 32'h3000) begin fails++; $display("FAIL sb_addr: got %h expected 00003000", a); end
        tests++; if (be !== 4'b0010) begin fails++; $display("FAIL sb_be: got %b expected 0010", be); end
        tests++; if (wd !== 32'hABAB_ABAB) begin fails++; $display("FAIL sb_wdata: got %h expected abababab", wd); end
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL sb_we: got %b expected 1", we); end
        tests++; if (lv !== 1'b0) begin fails++; $display("FAIL sb_no_load_valid: got %b expected 0", lv); end
        tests++; if (ld !== 32'hFFFF_BEEF) begin fails++; $display("FAIL sb_load_data_hold: got %h expected ffffbeef", ld); end
        transact(1'b0, 1'b1, 3'b010, 32'h3004, 32'h1234_5678, 32'h0, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (be !== 4'b1111) begin fails++; $display("FAIL sw_be: got %b expected 1111", be); end
        tests++; if (wd !== 32'h1234_5678) begin fails++; $display("FAIL sw_wdata: got %h expected 12345678", wd); end
        tests++; if (a !== 32'h3004) begin fails++; $display("FAIL sw_addr: got %h expected 00003004", a); end
        transact(1'b0, 1'b1, 3'b001, 32'h3006, 32'h5555_CAFE, 32'h0, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (be !== 4'b1100) begin fails++; $display("FAIL sh_be: got %b expected 1100", be); end
        tests++; if (wd !== 32'hCAFE_CAFE) begin fails++; $display("FAIL sh_wdata: got %h expected cafecafe", wd); end
    endtask

    task automatic test_wait();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        transact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 2, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (sc !== 4) begin fails++; $display("FAIL wait_stall_cycles: got %0d expected 4", sc); end
        tests++; if (ld !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wait_data: got %h expected deadbeef", ld); end
        tests++; if (lv !== 1'b1) begin fails++; $display("FAIL wait_load_valid: got %b expected 1", lv); end
    endtask

    task automatic test_faults();
        logic        rd_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        wr_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3_t [4] = '{3'b010, 3'b010, 3'b100, 3'b011};
        logic [31:0] ad_t [4] = '{32'h4002, 32'h4000, 32'h4000, 32'h4000};
        for (int k = 0; k < 4; k++) begin
            mem_read   = rd_t[k];
            mem_write  = wr_t[k];
            funct3     = f3_t[k];
            alu_result = ad_t[k];
            @(negedge clk);
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fault%0d_stall: got %b expected 0", k, stall); end
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            tests++; if (fault !== 1'b1) begin fails++; $display("FAIL fault%0d_pulse: got %b expected 1", k, fault); end
            tests++; if (dmem_req !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL fault%0d_req_state: got %b %0d expected 0 0", k, dmem_req, dbg_state); end
            @(posedge clk); #1;
            @(negedge clk);
            tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault%0d_end: got %b expected 0", k, fault); end
            @(posedge clk); #1;
        end
        tests++; if (load_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL fault_load_data_hold: got %h expected deadbeef", load_data); end
    endtask

    task automatic test_timeout();
        int busy;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        alu_result = 32'h40;
        dmem_ready = 1'b0;
        @(negedge clk);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL to_accept_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        mem_read = 1'b0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req) busy++;
            else break;
            @(posedge clk); #1;
        end
        tests++; if (busy !== 4) begin fails++; $display("FAIL to_busy_cycles: got %0d expected 4", busy); end
        tests++; if (fault !== 1'b1) begin fails++; $display("FAIL to_fault: got %b expected 1", fault); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL to_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (fault !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL to_after: got fault=%b req=%b expected 0 0", fault, dmem_req); end
        tests++; if (load_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL to_load_data_hold: got %h expected deadbeef", load_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        transact(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (ld !== 32'h0000_0080) begin fails++; $display("FAIL b2b_lbu_data: got %h expected 00000080", ld); end
        transact(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0BAD_F00D, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (sc !== 2) begin fails++; $display("FAIL b2b_stall_cycles: got %0d expected 2", sc); end
        tests++; if (ld !== 32'h0BAD_F00D) begin fails++; $display("FAIL b2b_lw_data: got %h expected 0badf00d", ld); end
    endtask

    task automatic test_reset_mid();
        int sc; logic rq, we, lv; logic [31:0] a, wd, ld; logic [3:0] be;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        funct3     = 3'b010;
        alu_result = 32'h50;
        dmem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        mem_read = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rm_busy_req: got %b expected 1", dmem_req); end
        rst = 1'b1;
        #1;
        tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rm_async_drop: got req=%b stall=%b expected 0 0", dmem_req, stall); end
        tests++; if (dmem_addr !== 32'd0 || load_data !== 32'd0) begin fails++; $display("FAIL rm_regs: got %h %h expected 0 0", dmem_addr, load_data); end
        tests++; if (fault !== 1'b0 || load_valid !== 1'b0) begin fails++; $display("FAIL rm_pulses: got %b %b expected 0 0", fault, load_valid); end
        @(posedge clk); #1;
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rm_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        transact(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1122_3344, 0, sc, rq, a, wd, be, we, lv, ld);
        tests++; if (sc !== 2) begin fails++; $display("FAIL rm_lw_stall: got %0d expected 2", sc); end
        tests++; if (a !== 32'h10) begin fails++; $display("FAIL rm_lw_addr: got %h expected 00000010", a); end
        tests++; if (lv !== 1'b1 || ld !== 32'h1122_3344) begin fails++; $display("FAIL rm_lw_data: got %b %h expected 1 11223344", lv, ld); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lb();
        test_lhu_lh();
        test_store();
        test_wait();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
